// File: rtl/xor_pkg.sv
// Purpose: shared limits and a saturating-increment helper for the xor_gate slice.
// Latency: n/a (constants and a pure function).
// Backpressure: none; no handshake anywhere in this slice.
package xor_pkg;

  localparam int XOR_WIDTH_MAX = 64;
  localparam int CNT_WIDTH_MAX = 32;

  // Increment value, clamping at the all-ones pattern of a `width`-bit field.
  // Shifting a 32-bit 1 by 32 yields 0, so the mask becomes all ones at full width.
  function automatic logic [CNT_WIDTH_MAX-1:0] sat_inc(
    input logic [CNT_WIDTH_MAX-1:0] value,
    input int                       width
  );
    logic [CNT_WIDTH_MAX-1:0] max_val;
    max_val = (CNT_WIDTH_MAX'(1) << width) - CNT_WIDTH_MAX'(1);
    if (value >= max_val) begin
      return max_val;
    end
    return value + CNT_WIDTH_MAX'(1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Purpose: 2-flop reset synchronizer, asserts asynchronously, deasserts on clk.
// Latency: assert immediate; deassert after 2 rising clk edges.
// Backpressure: none.
// Ports: clk (sync clock), rst_in (async active-high), rst_out (synchronized active-high).
module rst_sync (
  input  logic clk,
  input  logic rst_in,
  output logic rst_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      meta    <= 1'b1;
      rst_out <= 1'b1;
    end else begin
      meta    <= 1'b0;
      rst_out <= meta;
    end
  end

endmodule

// File: rtl/xor_gate.sv
// Purpose: bitwise XOR cell with combinational y plus registered copy, parity and nonzero count.
// Latency: y 0 cycles; y_q, parity_q, nz_cnt 1 cycle.
// Backpressure: none; a and b are sampled every cycle.
// Ports: clk, rst (async active-high), a/b operands, y = a^b, y_q, parity_q, nz_cnt.
module xor_gate
  import xor_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     y_q,
  output logic                 parity_q,
  output logic [CNT_WIDTH-1:0] nz_cnt
);

  if (WIDTH < 1 || WIDTH > XOR_WIDTH_MAX) begin : g_bad_width
    $error("xor_gate: WIDTH %0d outside 1..%0d", WIDTH, XOR_WIDTH_MAX);
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > CNT_WIDTH_MAX) begin : g_bad_cnt_width
    $error("xor_gate: CNT_WIDTH %0d outside 1..%0d", CNT_WIDTH, CNT_WIDTH_MAX);
  end

  // Pure combinational path: independent of clk and of the reset tree, so it
  // keeps working with the clock idle or reset held.
  assign y = a ^ b;

  logic rst_int;

  rst_sync u_rst_sync (
    .clk     (clk),
    .rst_in  (rst),
    .rst_out (rst_int)
  );

  logic [CNT_WIDTH_MAX-1:0] cnt_ext;
  logic [CNT_WIDTH_MAX-1:0] cnt_inc;

  assign cnt_ext = CNT_WIDTH_MAX'(nz_cnt);
  assign cnt_inc = sat_inc(cnt_ext, CNT_WIDTH);

  // rst_int asserts in the same instant as rst, so clearing is immediate;
  // release waits for the synchronizer.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      y_q      <= '0;
      parity_q <= 1'b0;
      nz_cnt   <= '0;
    end else begin
      y_q      <= y;
      parity_q <= ^y;
      if (|y) begin
        nz_cnt <= CNT_WIDTH'(cnt_inc);
      end
    end
  end

endmodule

// File: tb/tb_xor_gate.sv
module tb_xor_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Instance 1: plain 1-bit gate, clock and reset tied idle.
  logic clk_tie = 1'b0;
  logic rst_tie = 1'b0;
  logic a1, b1, y1, y1_q, par1;
  logic [7:0] cnt1;

  xor_gate #(.WIDTH(1), .CNT_WIDTH(8)) u_gate1 (
    .clk(clk_tie), .rst(rst_tie), .a(a1), .b(b1),
    .y(y1), .y_q(y1_q), .parity_q(par1), .nz_cnt(cnt1)
  );

  // Instance 2: 8-bit datapath.
  logic       rst8;
  logic [7:0] a8, b8, y8, y8_q;
  logic       par8;
  logic [7:0] cnt8;

  xor_gate #(.WIDTH(8), .CNT_WIDTH(8)) u_gate8 (
    .clk(clk), .rst(rst8), .a(a8), .b(b8),
    .y(y8), .y_q(y8_q), .parity_q(par8), .nz_cnt(cnt8)
  );

  // Instance 3: 2-bit counter to exercise saturation.
  logic       rstc;
  logic       ac, bc, yc, yc_q, parc;
  logic [1:0] cntc;

  xor_gate #(.WIDTH(1), .CNT_WIDTH(2)) u_gatec (
    .clk(clk), .rst(rstc), .a(ac), .b(bc),
    .y(yc), .y_q(yc_q), .parity_q(parc), .nz_cnt(cntc)
  );

  // Reference model: after reset falls, the first two edges are swallowed by
  // the release delay; every later edge captures a^b, its parity and a
  // clamped count of nonzero samples.
  int         m8_since = 0;
  logic [7:0] m8_yq    = '0;
  logic       m8_par   = 1'b0;
  int         m8_cnt   = 0;

  always @(posedge clk or posedge rst8) begin
    if (rst8) begin
      m8_since <= 0;
      m8_yq    <= '0;
      m8_par   <= 1'b0;
      m8_cnt   <= 0;
    end else begin
      if (m8_since >= 2) begin
        m8_yq  <= a8 ^ b8;
        m8_par <= ($countones(a8 ^ b8) % 2) == 1;
        if ((a8 ^ b8) != 8'd0 && m8_cnt < 255) m8_cnt <= m8_cnt + 1;
      end else begin
        m8_since <= m8_since + 1;
      end
    end
  end

  int   mc_since = 0;
  logic mc_yq    = 1'b0;
  int   mc_cnt   = 0;

  always @(posedge clk or posedge rstc) begin
    if (rstc) begin
      mc_since <= 0;
      mc_yq    <= 1'b0;
      mc_cnt   <= 0;
    end else begin
      if (mc_since >= 2) begin
        mc_yq <= ac ^ bc;
        if ((ac ^ bc) && mc_cnt < 3) mc_cnt <= mc_cnt + 1;
      end else begin
        mc_since <= mc_since + 1;
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_y8",    64'(y8),   64'(a8 ^ b8));
      chk("cmp_y8_q",  64'(y8_q), 64'(m8_yq));
      chk("cmp_par8",  64'(par8), 64'(m8_par));
      chk("cmp_cnt8",  64'(cnt8), 64'(m8_cnt));
      chk("cmp_yc",    64'(yc),   64'(ac ^ bc));
      chk("cmp_yc_q",  64'(yc_q), 64'(mc_yq));
      chk("cmp_parc",  64'(parc), 64'(mc_yq));
      chk("cmp_cntc",  64'(cntc), 64'(mc_cnt));
    end
  end

  logic [3:0] exp_tt  = 4'b0110;
  int         exp_sat [6] = '{1, 2, 3, 3, 3, 3};

  initial begin
    rst8 = 1'b1; rstc = 1'b1;
    a8 = '0; b8 = '0; ac = 1'b0; bc = 1'b0;
    a1 = 1'b0; b1 = 1'b0;

    // 1-bit truth table, clock idle on this instance.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #5;
      chk("tt_y1", 64'(y1), 64'(exp_tt[i]));
      #5;
    end

    // Reset state, and y live while reset is held.
    #1;
    chk("rst_y8_q", 64'(y8_q), 64'h0);
    chk("rst_par8", 64'(par8), 64'h0);
    chk("rst_cnt8", 64'(cnt8), 64'h0);
    chk("rst_cntc", 64'(cntc), 64'h0);
    chk_en = 1'b1;
    a8 = 8'hA5; b8 = 8'h0F;
    #1;
    chk("y8_a5_0f_in_rst", 64'(y8), 64'hAA);

    // Release: two edges hold zero, the third captures.
    @(posedge clk); #2;
    rst8 = 1'b0; rstc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("rel_hold_y8_q", 64'(y8_q), 64'h0);
      chk("rel_hold_cnt8", 64'(cnt8), 64'h0);
    end
    @(posedge clk); #2;
    chk("first_y8_q", 64'(y8_q), 64'hAA);
    chk("first_par8", 64'(par8), 64'h0);
    chk("first_cnt8", 64'(cnt8), 64'h1);
    @(posedge clk); #2;
    chk("second_cnt8", 64'(cnt8), 64'h2);

    // Equal operands: zero result, counter holds.
    a8 = 8'h3C; b8 = 8'h3C;
    #1;
    chk("eq_y8", 64'(y8), 64'h0);
    repeat (4) @(posedge clk);
    #2;
    chk("eq_y8_q", 64'(y8_q), 64'h0);
    chk("eq_cnt8", 64'(cnt8), 64'h2);

    // Odd parity result.
    a8 = 8'hFF; b8 = 8'h01;
    @(posedge clk); #2;
    chk("odd_y8_q", 64'(y8_q), 64'hFE);
    chk("odd_par8", 64'(par8), 64'h1);
    chk("odd_cnt8", 64'(cnt8), 64'h3);

    // Saturation on the 2-bit counter.
    ac = 1'b1; bc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #2;
      chk("sat_cntc", 64'(cntc), 64'(exp_sat[i]));
    end
    chk("sat_yc_q", 64'(yc_q), 64'h1);
    chk("sat_parc", 64'(parc), 64'h1);
    ac = 1'b1; bc = 1'b1;
    @(posedge clk); #2;
    chk("sat_hold_cntc", 64'(cntc), 64'h3);
    chk("sat_zero_yc_q", 64'(yc_q), 64'h0);

    // Mid-cycle reset clears without an edge; y keeps tracking.
    a8 = 8'h5A; b8 = 8'h00;
    @(posedge clk); #2;
    chk("pre_rst_y8_q", 64'(y8_q), 64'h5A);
    #1;
    rst8 = 1'b1;
    #1;
    chk("async_y8_q", 64'(y8_q), 64'h0);
    chk("async_par8", 64'(par8), 64'h0);
    chk("async_cnt8", 64'(cnt8), 64'h0);
    a8 = 8'h12; b8 = 8'h34;
    #1;
    chk("rst_y8_live", 64'(y8), 64'h26);
    @(posedge clk); #2;
    chk("rst_held_y8_q", 64'(y8_q), 64'h0);
    @(posedge clk); #2;
    rst8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #2;
      chk("rel2_hold_y8_q", 64'(y8_q), 64'h0);
    end
    @(posedge clk); #2;
    chk("rel2_y8_q", 64'(y8_q), 64'h26);
    chk("rel2_par8", 64'(par8), 64'h1);
    chk("rel2_cnt8", 64'(cnt8), 64'h1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
